clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 130 +++++++++++++
 tb/tb_clk_period_meter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period of a slow, asynchronous clock in clk_50 cycles, with
// lock detection (consecutive periods within TOL) and a no-edge timeout.
module clk_period_meter #(
    parameter int unsigned CNT_W          = 27,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned TOL            = 1000
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        TIMEDOUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               have_base_q, have_base_d;
    logic [CNT_W-1:0]   period_d;
    logic               period_valid_d, locked_d, timeout_d;
    logic               rise_c;
    logic               at_limit_c;
    logic [CNT_W-1:0]   diff_c;
    logic               within_tol_c;

    assign rise_c     = sync2_q & ~prev_q;
    assign at_limit_c = (cnt_q == CNT_LIMIT);

    // Unsigned |cnt - period| by ordered subtraction, so it never wraps.
    always_comb begin
        if (cnt_q >= period) begin
            diff_c = cnt_q - period;
        end else begin
            diff_c = period - cnt_q;
        end
    end

    assign within_tol_c = (32'(diff_c) <= TOL);

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = at_limit_c ? cnt_q : cnt_q + CNT_ONE;
        have_base_d    = have_base_q;
        period_d       = period;
        period_valid_d = 1'b0;
        locked_d       = locked;
        timeout_d      = timeout;

        if (rise_c) begin
            cnt_d = CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = MEASURE;
                end else if (at_limit_c) begin
                    state_d     = TIMEDOUT;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_base_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise_c) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    have_base_d    = 1'b1;
                    if (have_base_q) begin
                        locked_d = within_tol_c;
                    end
                end else if (at_limit_c) begin
                    state_d     = TIMEDOUT;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_base_d = 1'b0;
                end
            end
            TIMEDOUT: begin
                if (rise_c) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronizer, edge history and all state, cleared by synchronous reset.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            have_base_q  <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            have_base_q  <= have_base_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a table of rise-to-rise gaps with
// expected outputs, plus hand sequences for reset, timeout and the boundary.
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 8;

    logic             clk_50 = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         gap;
        logic       exp_pv;
        logic [7:0] exp_period;
        logic       exp_locked;
        logic       exp_timeout;
    } vec_t;

    vec_t tbl[8];

    clk_period_meter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (100),
        .TOL            (2)
    ) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_50 = ~clk_50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int pv, input int per,
                               input int lk, input int to);
        chk({tag, " period_valid"}, int'(period_valid), pv);
        chk({tag, " period"},       int'(period),       per);
        chk({tag, " locked"},       int'(locked),       lk);
        chk({tag, " timeout"},      int'(timeout),      to);
    endtask

    // Drive a rise, check outputs 3 cycles later and the pulse drop 1 cycle
    // after that; the next rise follows v.gap cycles after this one.
    task automatic apply_row(input vec_t v, input string tag);
        sig_in = 1'b1;
        tick(3);
        chk_outputs(tag, int'(v.exp_pv), int'(v.exp_period),
                    int'(v.exp_locked), int'(v.exp_timeout));
        tick(1);
        chk({tag, " pulse_drop"}, int'(period_valid), 0);
        sig_in = 1'b0;
        if (v.gap > 4) tick(v.gap - 4);
    endtask

    initial begin
        tbl[0] = '{20, 1'b0, 8'd0,  1'b0, 1'b0};
        tbl[1] = '{20, 1'b1, 8'd20, 1'b0, 1'b0};
        tbl[2] = '{20, 1'b1, 8'd20, 1'b1, 1'b0};
        tbl[3] = '{21, 1'b1, 8'd20, 1'b1, 1'b0};
        tbl[4] = '{22, 1'b1, 8'd21, 1'b1, 1'b0};
        tbl[5] = '{30, 1'b1, 8'd22, 1'b1, 1'b0};
        tbl[6] = '{30, 1'b1, 8'd30, 1'b0, 1'b0};
        tbl[7] = '{4,  1'b1, 8'd30, 1'b1, 1'b0};

        // Reset with sig_in toggling, then idle into timeout.
        rst_n  = 1'b0;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in;
            tick(1);
        end
        chk_outputs("reset", 0, 0, 0, 0);
        rst_n  = 1'b1;
        sig_in = 1'b0;
        tick(100);
        chk("idle_pre_timeout", int'(timeout), 0);
        tick(1);
        chk_outputs("idle_timeout", 0, 0, 0, 1);

        // Steady and jittered periods.
        for (int i = 0; i < 8; i++) begin
            apply_row(tbl[i], $sformatf("row%0d", i));
        end

        // Last rise was driven 4 cycles ago; timeout lands 103 cycles after it.
        tick(98);
        chk("gap_pre_timeout", int'(timeout), 0);
        tick(1);
        chk_outputs("gap_timeout", 0, 30, 0, 1);
        tick(5);

        // Restart after timeout, then the 100/101-cycle boundary.
        apply_row('{20,  1'b0, 8'd30,  1'b0, 1'b0}, "restart0");
        apply_row('{100, 1'b1, 8'd20,  1'b0, 1'b0}, "restart1");
        apply_row('{101, 1'b1, 8'd100, 1'b0, 1'b0}, "bound100");
        sig_in = 1'b1;
        tick(2);
        chk_outputs("bound101_timeout", 0, 100, 0, 1);
        tick(1);
        chk_outputs("bound101_rise", 0, 100, 0, 0);
        tick(1);
        chk("bound101_nopulse", int'(period_valid), 0);
        sig_in = 1'b0;
        tick(16);
        apply_row('{20, 1'b1, 8'd20, 1'b0, 1'b0}, "post_to0");
        apply_row('{10, 1'b1, 8'd20, 1'b1, 1'b0}, "post_to1");

        // One-cycle reset 10 cycles into a measurement.
        rst_n = 1'b0;
        tick(1);
        chk_outputs("mid_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(9);
        apply_row('{20, 1'b0, 8'd0,  1'b0, 1'b0}, "after_rst0");
        apply_row('{4,  1'b1, 8'd20, 1'b0, 1'b0}, "after_rst1");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
